chunked_add_sequencer: RTL

Multi-cycle wide integer adder/subtractor. It time-multiplexes one N-bit rippleCarryAdder slice across W/N chunks, least-significant chunk first, and registers the carry between chunks. It is used where a full-width ripple chain would break timing, such as wide mantissa/significand accumulation in the float datapath. Operands arrive and results leave through valid/ready handshakes.

---
 rtl/chunked_add_pkg.sv | 11 +
 rtl/chunked_add_sequencer_rca.sv | 23 ++
 rtl/chunked_add_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/chunked_add_pkg.sv
// Shared types and sizing helpers for the chunked wide adder/subtractor.
package chunked_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    // Chunk index needs at least one bit even when there is a single chunk.
    function automatic int idx_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/chunked_add_sequencer_rca.sv
// N-bit combinational ripple-carry slice, reused once per chunk by the sequencer.
module rippleCarryAdder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    always_comb begin
        logic c;
        c      = cin_i;
        sum_o  = '0;
        for (int i = 0; i < N; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end

endmodule

// File: rtl/chunked_add_sequencer.sv
// Wide add/subtract computed LS chunk first through one N-bit slice,
// carry registered between chunks; valid/ready on both sides.
//
// state | meaning
// IDLE  | ready for an operand bundle
// RUN   | one slice chunk per cycle, LS chunk first
// DONE  | result held until the consumer takes it
module chunked_add_sequencer
    import chunked_add_pkg::*;
#(
    parameter int W = 64,
    parameter int N = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         overflow_o
);

    localparam int CHUNKS = W / N;
    localparam int IW     = idx_width(CHUNKS);
    localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

    if ((W % N) != 0 || W < N) begin : g_bad_width
        $error("chunked_add_sequencer: W must be a positive multiple of N");
    end

    seq_state_t    state_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic [W-1:0]  a_q, b_q, sum_q;
    logic          cout_q, ovf_q, in_ready_q, out_valid_q;

    logic [N-1:0]  a_chunk, b_chunk, slice_sum;
    logic          slice_cout;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            if (idx_q == IW'(i)) begin
                a_chunk = a_q[i*N +: N];
                b_chunk = b_q[i*N +: N];
            end
        end
    end

    rippleCarryAdder #(.N(N)) u_slice (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        // Subtraction is a + ~b + 1, the +1 entering as carry-in.
                        a_q        <= a_i;
                        b_q        <= sub_i ? ~b_i : b_i;
                        carry_q    <= sub_i;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < CHUNKS; i++) begin
                        if (idx_q == IW'(i)) sum_q[i*N +: N] <= slice_sum;
                    end
                    carry_q <= slice_cout;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= slice_cout;
                        ovf_q       <= (a_q[W-1] == b_q[W-1]) && (slice_sum[N-1] != a_q[W-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign overflow_o  = ovf_q;

endmodule
